// File: rtl/wash_panel_ctrl.sv
// Washing-machine front panel: input conditioning, program select, start/lock FSM.
// Define WASH_PANEL_WATCHDOG_EN to add the RUN-state watchdog and timeout_err.
module wash_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_PROGRAMS    = 4,
  parameter int UNLOCK_CYCLES   = 3,
  parameter int WDOG_CYCLES     = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power,
  input  logic       start_btn_raw,
  input  logic       prog_btn_raw,
  input  logic       door_sw_raw,
  input  logic       soap_sw_raw,
  input  logic       program_done,
  output logic       start,
  output logic [2:0] program_selection,
  output logic       doorclosed,
  output logic       soap,
  output logic       door_lock,
  output logic       door_warning,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_START,
    S_RUN,
    S_UNLOCK
  } state_t;

  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] UNL_INIT = 8'(UNLOCK_CYCLES);
  localparam logic [2:0] SEL_LAST = 3'(NUM_PROGRAMS - 1);

  // bit order: 0 start, 1 prog, 2 door, 3 soap
  logic [3:0]      raw;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      db;
  logic [3:0]      db_nxt;
  logic [3:0][7:0] cnt;
  logic [3:0][7:0] cnt_nxt;
  logic [2:0]      rise;

  state_t     state;
  logic [7:0] unl_cnt;
  logic [2:0] sel_next;
  logic       start_edge;
  logic       prog_edge;
  logic       door_rise;

  assign raw = {soap_sw_raw, door_sw_raw,
                prog_btn_raw, start_btn_raw};

  always_comb begin
    db_nxt  = db;
    cnt_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2[i] != db[i]) begin
        if (cnt[i] == DB_LAST) begin
          db_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      cnt   <= '0;
      rise  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db    <= db_nxt;
      cnt   <= cnt_nxt;
      rise  <= db_nxt[2:0] & ~db[2:0];
    end
  end

  assign start_edge = rise[0];
  assign prog_edge  = rise[1];
  assign door_rise  = rise[2];

  assign sel_next = (program_selection == SEL_LAST) ?
                    3'd0 : program_selection + 3'd1;

  assign doorclosed = db[2] & (state != S_OFF);
  assign soap       = db[3] & (state != S_OFF);

`ifdef WASH_PANEL_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WDOG_CYCLES - 1);

  logic [WDW-1:0] wd_cnt;
  logic           tmo;

  assign timeout_err = tmo;
`else
  logic unused_cfg;

  assign unused_cfg  = (WDOG_CYCLES == 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_OFF;
      start             <= 1'b0;
      program_selection <= 3'd0;
      door_lock         <= 1'b0;
      door_warning      <= 1'b0;
      busy              <= 1'b0;
      unl_cnt           <= 8'd0;
`ifdef WASH_PANEL_WATCHDOG_EN
      wd_cnt            <= '0;
      tmo               <= 1'b0;
`endif
    end else if (!power) begin
      state        <= S_OFF;
      start        <= 1'b0;
      door_lock    <= 1'b0;
      door_warning <= 1'b0;
      busy         <= 1'b0;
      unl_cnt      <= 8'd0;
    end else begin
      start <= 1'b0;
      unique case (state)
        S_OFF: begin
          state <= S_IDLE;
        end
        S_IDLE: begin
          if (start_edge && db[2]) begin
            state        <= S_START;
            start        <= 1'b1;
            door_lock    <= 1'b1;
            busy         <= 1'b1;
            door_warning <= 1'b0;
`ifdef WASH_PANEL_WATCHDOG_EN
            tmo          <= 1'b0;
`endif
          end else if (start_edge) begin
            door_warning <= 1'b1;
          end else begin
            if (prog_edge) begin
              program_selection <= sel_next;
            end
            if (door_rise) begin
              door_warning <= 1'b0;
            end
          end
        end
        S_START: begin
          state <= S_RUN;
`ifdef WASH_PANEL_WATCHDOG_EN
          wd_cnt <= '0;
`endif
        end
        S_RUN: begin
          if (program_done) begin
            state   <= S_UNLOCK;
            unl_cnt <= UNL_INIT;
          end
`ifdef WASH_PANEL_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            state   <= S_UNLOCK;
            unl_cnt <= UNL_INIT;
            tmo     <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_UNLOCK: begin
          // lock stays for exactly UNLOCK_CYCLES cycles
          if (unl_cnt <= 8'd1) begin
            state     <= S_IDLE;
            door_lock <= 1'b0;
            busy      <= 1'b0;
            unl_cnt   <= 8'd0;
          end else begin
            unl_cnt <= unl_cnt - 8'd1;
          end
        end
        default: begin
          state <= S_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Scoreboard bench for wash_panel_ctrl: debounce, selection, start/lock,
// unlock timing, power abort, watchdog and async reset.
module tb_wash_panel_ctrl;

  localparam int NP = 4;

  logic       clk;
  logic       rst;
  logic       power;
  logic       start_btn_raw;
  logic       prog_btn_raw;
  logic       door_sw_raw;
  logic       soap_sw_raw;
  logic       program_done;
  logic       start;
  logic [2:0] program_selection;
  logic       doorclosed;
  logic       soap;
  logic       door_lock;
  logic       door_warning;
  logic       busy;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_start = 0;
  int sel_model = 0;
  int hi;
  int n;
  int exp_sel[$];
  int exp_start[$];

  wash_panel_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .NUM_PROGRAMS(NP),
    .UNLOCK_CYCLES(3),
    .WDOG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .power(power),
    .start_btn_raw(start_btn_raw),
    .prog_btn_raw(prog_btn_raw),
    .door_sw_raw(door_sw_raw),
    .soap_sw_raw(soap_sw_raw),
    .program_done(program_done),
    .start(start),
    .program_selection(program_selection),
    .doorclosed(doorclosed),
    .soap(soap),
    .door_lock(door_lock),
    .door_warning(door_warning),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // raw press held 8 cycles, released 8 cycles
  task automatic press(input bit s, input bit p,
                       input bit want_start, input bit want_sel);
    if (want_start) exp_start.push_back(cyc + 7);
    if (want_sel) begin
      sel_model = (sel_model + 1) % NP;
      exp_sel.push_back(sel_model);
    end
    start_btn_raw = s;
    prog_btn_raw  = p;
    tick(8);
    start_btn_raw = 1'b0;
    prog_btn_raw  = 1'b0;
    tick(8);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (start) begin
        if (exp_start.size() == 0)
          check("start_unexp", int'(start), 0);
        else
          check("start_cyc", cyc, exp_start.pop_front());
        last_start <= cyc;
      end
      if (program_selection != 3'(sel_model) || exp_sel.size() != 0) begin
        if (exp_sel.size() == 0)
          check("sel_frozen", int'(program_selection), sel_model);
        else if (program_selection == 3'(exp_sel[0]))
          check("sel_val", int'(program_selection), exp_sel.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0;
    power = 1'b0;
    start_btn_raw = 1'b0;
    prog_btn_raw = 1'b0;
    door_sw_raw = 1'b0;
    soap_sw_raw = 1'b0;
    program_done = 1'b0;
    tick(3);
    check("rst_start", int'(start), 0);
    check("rst_sel", int'(program_selection), 0);
    check("rst_lock", int'(door_lock), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_warn", int'(door_warning), 0);
    check("rst_door", int'(doorclosed), 0);
    check("rst_tmo", int'(timeout_err), 0);
    rst = 1'b1;
    tick(2);
    power = 1'b1;
    tick(3);
    check("idle_busy", int'(busy), 0);

    door_sw_raw = 1'b1;
    tick(3);
    door_sw_raw = 1'b0;
    hi = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      hi += int'(doorclosed);
    end
    check("glitch_door", hi, 0);

    door_sw_raw = 1'b1;
    soap_sw_raw = 1'b1;
    tick(5);
    check("door_early", int'(doorclosed), 0);
    tick(1);
    check("door_lat", int'(doorclosed), 1);
    check("soap_lat", int'(soap), 1);

    for (int k = 0; k < 5; k++) press(1'b0, 1'b1, 1'b0, 1'b1);
    check("sel_wrap", int'(program_selection), 1);
    check("selq_empty", exp_sel.size(), 0);

    press(1'b1, 1'b0, 1'b1, 1'b0);
    check("start_seen", exp_start.size(), 0);
    check("run_lock", int'(door_lock), 1);
    check("run_busy", int'(busy), 1);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("run_sel", int'(program_selection), 1);
    check("run_lock2", int'(door_lock), 1);

    program_done = 1'b1;
    tick(1);
    program_done = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      n += int'(door_lock);
      tick(1);
    end
    check("unlock_len", n, 3);
    check("done_lock", int'(door_lock), 0);
    check("done_busy", int'(busy), 0);
    program_done = 1'b1;
    tick(2);
    program_done = 1'b0;
    tick(2);
    check("done_idle_ign", int'(door_lock), 0);

    door_sw_raw = 1'b0;
    tick(10);
    check("door_open", int'(doorclosed), 0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("warn_set", int'(door_warning), 1);
    check("warn_busy", int'(busy), 0);
    door_sw_raw = 1'b1;
    tick(10);
    check("warn_clr", int'(door_warning), 0);

    press(1'b1, 1'b1, 1'b1, 1'b0);
    check("both_sel", int'(program_selection), 1);
    check("both_busy", int'(busy), 1);

    power = 1'b0;
    tick(1);
    check("abort_lock", int'(door_lock), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_door", int'(doorclosed), 0);
    check("abort_sel", int'(program_selection), 1);
    power = 1'b1;
    tick(3);
    check("pwr_door", int'(doorclosed), 1);
    check("pwr_busy", int'(busy), 0);

    press(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef WASH_PANEL_WATCHDOG_EN
    n = 0;
    while (!timeout_err && n < 100) begin
      tick(1);
      n++;
    end
    check("wdog_err", int'(timeout_err), 1);
    check("wdog_lat", cyc - last_start, 21);
    tick(5);
    check("wdog_unlock", int'(door_lock), 0);
    check("wdog_sticky", int'(timeout_err), 1);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    check("wdog_clr", int'(timeout_err), 0);
`else
    tick(40);
    check("nowd_busy", int'(busy), 1);
    check("nowd_tmo", int'(timeout_err), 0);
`endif
    program_done = 1'b1;
    tick(1);
    program_done = 1'b0;
    tick(8);
    check("wd_end_busy", int'(busy), 0);

    press(1'b1, 1'b0, 1'b1, 1'b0);
    check("rst_run_lock", int'(door_lock), 1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_lock", int'(door_lock), 0);
    check("rst_async_sel", int'(program_selection), 0);
    check("rst_async_busy", int'(busy), 0);
    sel_model = 0;
    tick(2);
    rst = 1'b1;
    tick(3);
    check("post_rst_busy", int'(busy), 0);

    check("startq_empty", exp_start.size(), 0);
    check("selq_final", exp_sel.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wash_panel_ctrl.md
Name: wash_panel_ctrl

Overview:
Front-panel input stage that sits directly upstream of the washing-machine FSM (FSMW). It synchronises and debounces the raw panel buttons and sensors, and cycles and latches the program selection. It issues a single-cycle start pulse only when the door is closed, and holds the door lock from start until the FSM reports program_done plus an unlock delay. Its outputs connect to the FSM inputs of the same names: start, program_selection, doorclosed, soap.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a debounced output changes (1..255)
NUM_PROGRAMS, 4, number of selectable programs; program_selection wraps modulo this value (2..8)
UNLOCK_CYCLES, 3, cycles door_lock stays high after program_done (1..255)
WDOG_CYCLES, 2000, RUN-state watchdog limit; used only with the optional feature

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
power  input  1  mains enable, already synchronous to clk
start_btn_raw  input  1  raw start button, asynchronous, active-high
prog_btn_raw  input  1  raw program-select button, asynchronous, active-high
door_sw_raw  input  1  raw door switch, asynchronous, 1 = closed
soap_sw_raw  input  1  raw soap sensor, asynchronous, 1 = soap present
program_done  input  1  from FSMW, level or pulse
start  output  1  one-cycle start pulse to FSMW
program_selection  output  3  latched program code to FSMW
doorclosed  output  1  debounced door switch
soap  output  1  debounced soap sensor
door_lock  output  1  door solenoid drive
door_warning  output  1  start was rejected because the door was open
busy  output  1  high in START, RUN and UNLOCK
timeout_err  output  1  watchdog fault, sticky (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state OFF; every output 0; program_selection 3'd0; synchronisers, debounce counters and unlock/watchdog counters 0.
- Input conditioning, per raw input:
  - 2-flop synchroniser, then a counter.
  - The counter increments while the synchronised value differs from the debounced value. It clears when the two agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced value takes the new value and the counter clears.
  - Total latency from a raw change to the debounced output: 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no output change.
- Edge detect: a registered rising-edge strobe on debounced start_btn and prog_btn.
- State machine (registered):
  - OFF: all control outputs 0. power=1 -> IDLE.
  - IDLE:
    - Start edge with doorclosed=1 -> START; door_warning clears.
    - Start edge with doorclosed=0 -> stay in IDLE; door_warning=1 until doorclosed rises.
    - Prog edge (no start edge in the same cycle) -> program_selection = (program_selection+1) mod NUM_PROGRAMS.
    - Simultaneous start and prog edges: start wins; the selection is unchanged.
  - START: start=1 for exactly this one cycle; door_lock=1 -> RUN.
  - RUN:
    - door_lock=1. Prog and start edges are ignored; program_selection is frozen.
    - program_done=1 -> UNLOCK; the unlock counter loads UNLOCK_CYCLES.
  - UNLOCK: door_lock=1; the counter decrements each cycle; on reaching 0 -> IDLE with door_lock=0.
- power=0 in any state -> OFF on the next edge; start, door_lock, busy and door_warning are forced to 0. program_selection is retained.
- program_done outside RUN is ignored.
- Debounced doorclosed and soap are forwarded in every state except OFF. In OFF they are 0.
- Reset mid-RUN: immediate return to reset values; door_lock drops asynchronously.

Optional Feature:
Macro WASH_PANEL_WATCHDOG_EN.
- Defined:
  - A watchdog counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches WDOG_CYCLES without program_done -> UNLOCK and timeout_err=1.
  - timeout_err stays high until the next accepted start or until reset.
- Not defined: the counter is absent, timeout_err is tied to 0, and RUN waits indefinitely.

Test Plan:
- Debounce (DEBOUNCE_CYCLES=4): pulse door_sw_raw high for 3 cycles -> doorclosed stays 0. Hold it high -> doorclosed rises exactly 6 cycles after the first sampled high.
- Selection wrap (NUM_PROGRAMS=4): 5 clean prog presses from reset -> program_selection sequence 1,2,3,0,1.
- Start with door closed: start press -> exactly one start=1 cycle, one cycle after the debounced edge. door_lock=1 from START onward. A prog press in RUN leaves program_selection unchanged.
- Start with door open: start press -> no start pulse, door_warning=1, state IDLE. Closing the door -> door_warning=0.
- Completion (UNLOCK_CYCLES=3): program_done pulsed in RUN -> door_lock held for 3 further cycles after entering UNLOCK, then 0. busy=0 and state IDLE.
- Abort and watchdog: power=0 mid-RUN -> door_lock=0 and state OFF next edge. With WASH_PANEL_WATCHDOG_EN and WDOG_CYCLES=20, no program_done -> timeout_err=1 and UNLOCK entered after 20 RUN cycles.
